// File: rtl/motoro3_regbank_pkg.sv
// Shared constants for the motor-3 runtime register bank: bus address map,
// CTRL/STATUS bit positions, field widths, reset values and the commit
// state type. Optional feature macro used by the bank: M3REG_RAMP_EN.
package motoro3_pkg;

    localparam int unsigned M3_ADDR_W        = 3;
    localparam int unsigned M3_DATA_W        = 32;

    localparam int unsigned M3_RELOAD_W      = 25;
    localparam int unsigned M3_PWM_W         = 12;
    localparam int unsigned M3_PCT_W         = 8;

    localparam int unsigned M3_RELOAD_RST    = 1666667;
    localparam int unsigned M3_PCT_RST       = 16;
    localparam int unsigned M3_PWM_LEN_RST   = 512;
    localparam int unsigned M3_PWM_MIN_RST   = 32;
    localparam int unsigned M3_PWM_MIN_FLOOR = 32;
    localparam int unsigned M3_RAMP_STEP     = 1024;

    localparam logic [M3_ADDR_W-1:0] M3A_RELOAD = 3'd0;
    localparam logic [M3_ADDR_W-1:0] M3A_PCT    = 3'd1;
    localparam logic [M3_ADDR_W-1:0] M3A_LEN    = 3'd2;
    localparam logic [M3_ADDR_W-1:0] M3A_MIN    = 3'd3;
    localparam logic [M3_ADDR_W-1:0] M3A_CTRL   = 3'd4;
    localparam logic [M3_ADDR_W-1:0] M3A_STATUS = 3'd5;
    localparam logic [M3_ADDR_W-1:0] M3A_NOW    = 3'd6;

    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_ERRCLR_BIT = 1;
    localparam int unsigned ST_PEND_BIT     = 0;
    localparam int unsigned ST_RAMP_BIT     = 1;
    localparam int unsigned ST_ERR_BIT      = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } commit_state_e;

endpackage

// File: rtl/motoro3_regbank_if.sv
// Register-bank bus: single-cycle write/read strobes, registered read data.
interface motoro3_regbank_if;
    import motoro3_pkg::*;

    logic                 bus_wr;
    logic                 bus_rd;
    logic [M3_ADDR_W-1:0] bus_addr;
    logic [M3_DATA_W-1:0] bus_wdata;
    logic [M3_DATA_W-1:0] bus_rdata;
    logic                 bus_rvalid;

    modport master (
        output bus_wr, bus_rd, bus_addr, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_wr, bus_rd, bus_addr, bus_wdata,
        output bus_rdata, bus_rvalid
    );

endinterface

// File: rtl/motoro3_regbank_ramp.sv
// Slew limiter: on each step_tick the held value moves toward tgt by at most
// STEP, never overshooting. load snaps the value straight to tgt.
module motoro3_ramp
    import motoro3_pkg::*;
#(
    parameter int unsigned W       = M3_RELOAD_W,
    parameter int unsigned STEP    = M3_RAMP_STEP,
    parameter int unsigned RST_VAL = M3_RELOAD_RST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_tick,
    input  logic         load,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] now
);

    logic [W-1:0] now_q;
    logic [W-1:0] now_d;
    logic [W-1:0] diff;
    logic [W-1:0] delta;

    // Next value: snap on load, otherwise bounded step toward the target
    always_comb begin
        now_d = now_q;
        diff  = (now_q > tgt) ? (now_q - tgt) : (tgt - now_q);
        delta = (diff > W'(STEP)) ? W'(STEP) : diff;
        if (load) begin
            now_d = tgt;
        end else if (step_tick && (now_q != tgt)) begin
            now_d = (now_q > tgt) ? (now_q - delta) : (now_q + delta);
        end
    end

    // Value register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) now_q <= W'(RST_VAL);
        else     now_q <= now_d;
    end

    assign now = now_q;

endmodule

// File: rtl/motoro3_regbank.sv
// Motor-3 runtime register bank. Bus-writable shadows for reload, power and
// PWM constants are validated and committed atomically at a PWM period
// boundary. With M3REG_RAMP_EN defined the active reload slews toward its
// target once per commutation step; otherwise it follows the target on apply.
module motoro3_regbank
    import motoro3_pkg::*;
#(
    parameter int unsigned RELOAD_W      = M3_RELOAD_W,
    parameter int unsigned PWM_W         = M3_PWM_W,
    parameter int unsigned PCT_W         = M3_PCT_W,
    parameter int unsigned RELOAD_RST    = M3_RELOAD_RST,
    parameter int unsigned PCT_RST       = M3_PCT_RST,
    parameter int unsigned PWM_LEN_RST   = M3_PWM_LEN_RST,
    parameter int unsigned PWM_MIN_RST   = M3_PWM_MIN_RST,
    parameter int unsigned PWM_MIN_FLOOR = M3_PWM_MIN_FLOOR,
    parameter int unsigned RAMP_STEP     = M3_RAMP_STEP
) (
    input  logic                clk,
    input  logic                rst,
    motoro3_regbank_if.slave    bus,
    input  logic                pwm_sync,
    input  logic                step_tick,
    output logic [RELOAD_W-1:0] m3reg_step_cnt_reload1,
    output logic [PCT_W-1:0]    m3reg_power_percent,
    output logic [PWM_W-1:0]    pwmLenWant,
    output logic [PWM_W-1:0]    pwmMinMask,
    output logic                m3reg_busy,
    output logic                m3reg_err
);

    logic [RELOAD_W-1:0]  sh_reload_q, sh_reload_d;
    logic [PCT_W-1:0]     sh_pct_q,    sh_pct_d;
    logic [PWM_W-1:0]     sh_len_q,    sh_len_d;
    logic [PWM_W-1:0]     sh_min_q,    sh_min_d;
    logic [PCT_W-1:0]     pct_q,       pct_d;
    logic [PWM_W-1:0]     len_q,       len_d;
    logic [PWM_W-1:0]     min_q,       min_d;
    logic [RELOAD_W-1:0]  reload_tgt_q, reload_tgt_d;
    commit_state_e        state_q,     state_d;
    logic                 err_q,       err_d;
    logic [M3_DATA_W-1:0] rdata_q,     rdata_d;
    logic                 rvalid_q,    rvalid_d;

    logic                 commit_wr;
    logic                 errclr_wr;
    logic                 apply;
    logic                 shadow_ok;
    logic                 accept;
    logic                 reject;
    logic                 pending;
    logic                 ramp_busy;
    logic [RELOAD_W-1:0]  reload_now;
    logic [M3_DATA_W-1:0] rd_mux;

    // CTRL decode and commit FSM; a commit write masks a coincident pwm_sync
    always_comb begin
        commit_wr = bus.bus_wr && (bus.bus_addr == M3A_CTRL) && bus.bus_wdata[CTRL_COMMIT_BIT];
        errclr_wr = bus.bus_wr && (bus.bus_addr == M3A_CTRL) && bus.bus_wdata[CTRL_ERRCLR_BIT];
        state_d   = state_q;
        apply     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_wr) state_d = PEND;
            end
            PEND: begin
                if (commit_wr) begin
                    state_d = PEND;
                end else if (pwm_sync) begin
                    apply   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow validation at apply time
    always_comb begin
        shadow_ok = (sh_min_q >= PWM_W'(PWM_MIN_FLOOR)) && (sh_min_q < sh_len_q) && (sh_len_q != '0);
        accept    = apply && shadow_ok;
        reject    = apply && !shadow_ok;
        pending   = (state_q == PEND);
    end

    // Shadow writes (truncated to field width), active loads, sticky error
    always_comb begin
        sh_reload_d  = sh_reload_q;
        sh_pct_d     = sh_pct_q;
        sh_len_d     = sh_len_q;
        sh_min_d     = sh_min_q;
        pct_d        = pct_q;
        len_d        = len_q;
        min_d        = min_q;
        reload_tgt_d = reload_tgt_q;
        err_d        = err_q;
        if (bus.bus_wr) begin
            unique case (bus.bus_addr)
                M3A_RELOAD: sh_reload_d = RELOAD_W'(bus.bus_wdata);
                M3A_PCT:    sh_pct_d    = PCT_W'(bus.bus_wdata);
                M3A_LEN:    sh_len_d    = PWM_W'(bus.bus_wdata);
                M3A_MIN:    sh_min_d    = PWM_W'(bus.bus_wdata);
                default:    ;
            endcase
        end
        if (accept) begin
            pct_d        = (sh_pct_q == '0) ? PCT_W'(1) : sh_pct_q;
            len_d        = sh_len_q;
            min_d        = sh_min_q;
            reload_tgt_d = (sh_reload_q == '0) ? RELOAD_W'(1) : sh_reload_q;
        end
        if (errclr_wr) err_d = 1'b0;
        if (reject)    err_d = 1'b1;
    end

    // Read mux over current register state; a same-cycle write is not visible
    always_comb begin
        rd_mux = '0;
        unique case (bus.bus_addr)
            M3A_RELOAD: rd_mux = M3_DATA_W'(sh_reload_q);
            M3A_PCT:    rd_mux = M3_DATA_W'(sh_pct_q);
            M3A_LEN:    rd_mux = M3_DATA_W'(sh_len_q);
            M3A_MIN:    rd_mux = M3_DATA_W'(sh_min_q);
            M3A_STATUS: begin
                rd_mux[ST_PEND_BIT] = pending;
                rd_mux[ST_RAMP_BIT] = ramp_busy;
                rd_mux[ST_ERR_BIT]  = err_q;
            end
            M3A_NOW:    rd_mux = M3_DATA_W'(reload_now);
            default:    rd_mux = '0;
        endcase
        rdata_d  = bus.bus_rd ? rd_mux : '0;
        rvalid_d = bus.bus_rd;
    end

    // Register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reload_q  <= RELOAD_W'(RELOAD_RST);
            sh_pct_q     <= PCT_W'(PCT_RST);
            sh_len_q     <= PWM_W'(PWM_LEN_RST);
            sh_min_q     <= PWM_W'(PWM_MIN_RST);
            pct_q        <= PCT_W'(PCT_RST);
            len_q        <= PWM_W'(PWM_LEN_RST);
            min_q        <= PWM_W'(PWM_MIN_RST);
            reload_tgt_q <= RELOAD_W'(RELOAD_RST);
            state_q      <= IDLE;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            sh_reload_q  <= sh_reload_d;
            sh_pct_q     <= sh_pct_d;
            sh_len_q     <= sh_len_d;
            sh_min_q     <= sh_min_d;
            pct_q        <= pct_d;
            len_q        <= len_d;
            min_q        <= min_d;
            reload_tgt_q <= reload_tgt_d;
            state_q      <= state_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

`ifdef M3REG_RAMP_EN
    // Slew is driven purely by the registered target, so a step_tick coinciding
    // with an accepted apply still steps toward the previous target.
    motoro3_ramp #(
        .W       (RELOAD_W),
        .STEP    (RAMP_STEP),
        .RST_VAL (RELOAD_RST)
    ) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .step_tick (step_tick),
        .load      (1'b0),
        .tgt       (reload_tgt_q),
        .now       (reload_now)
    );

    assign ramp_busy = (reload_now != reload_tgt_q);
`else
    // Without slewing the active reload is the committed target itself.
    localparam int unsigned ramp_step_unused = RAMP_STEP;
    logic step_tick_unused;

    assign step_tick_unused = step_tick;
    assign reload_now       = reload_tgt_q;
    assign ramp_busy        = 1'b0;
`endif

    assign m3reg_step_cnt_reload1 = reload_now;
    assign m3reg_power_percent    = pct_q;
    assign pwmLenWant             = len_q;
    assign pwmMinMask             = min_q;
    assign m3reg_busy             = ramp_busy | pending;
    assign m3reg_err              = err_q;
    assign bus.bus_rdata          = rdata_q;
    assign bus.bus_rvalid         = rvalid_q;

endmodule

// File: tb/tb_motoro3_regbank.sv
// Self-checking bench for motoro3_regbank: directed scenarios followed by
// randomized bus/sync/tick traffic, all compared against a behavioural model.
module tb_motoro3_regbank;

`ifdef M3REG_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pwm_sync;
    logic        step_tick;
    logic [24:0] reload_out;
    logic [7:0]  pct_out;
    logic [11:0] len_out;
    logic [11:0] min_out;
    logic        busy_out;
    logic        err_out;

    motoro3_regbank_if bus_if ();

    motoro3_regbank dut (
        .clk                    (clk),
        .rst                    (rst),
        .bus                    (bus_if),
        .pwm_sync               (pwm_sync),
        .step_tick              (step_tick),
        .m3reg_step_cnt_reload1 (reload_out),
        .m3reg_power_percent    (pct_out),
        .pwmLenWant             (len_out),
        .pwmMinMask             (min_out),
        .m3reg_busy             (busy_out),
        .m3reg_err              (err_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    // Behavioural model state
    logic [31:0] m_sh [4];
    logic [31:0] m_pct, m_len, m_min, m_tgt, m_now;
    bit          m_pend, m_err;
    logic [31:0] exp_rdata;
    bit          exp_rvalid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] field_mask(input logic [2:0] a);
        case (a)
            3'd0:    return 32'h01FF_FFFF;
            3'd1:    return 32'h0000_00FF;
            default: return 32'h0000_0FFF;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        if (a < 3'd4) return m_sh[a];
        if (a == 3'd5) return {29'd0, m_err, (m_now != m_tgt), m_pend};
        if (a == 3'd6) return m_now;
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_sh[0] = 1666667; m_sh[1] = 16; m_sh[2] = 512; m_sh[3] = 32;
        m_pct = 16; m_len = 512; m_min = 32; m_tgt = 1666667; m_now = 1666667;
        m_pend = 0; m_err = 0; exp_rdata = 0; exp_rvalid = 0;
    endtask

    // Advance the model over one clock edge given that cycle's inputs
    task automatic model_step(input logic wr, input logic rd, input logic [2:0] a,
                              input logic [31:0] d, input logic sync, input logic tick);
        bit commit, clr, apply, ok;
        logic [31:0] diff, stp;
        exp_rvalid = rd;
        exp_rdata  = rd ? model_read(a) : 32'd0;
        commit = wr && (a == 3'd4) && d[0];
        clr    = wr && (a == 3'd4) && d[1];
        apply  = m_pend && sync && !commit;
        ok     = (m_sh[3] >= 32) && (m_sh[3] < m_sh[2]) && (m_sh[2] != 0);
        if (RAMP_EN && tick && (m_now != m_tgt)) begin
            diff  = (m_now > m_tgt) ? m_now - m_tgt : m_tgt - m_now;
            stp   = (diff < 1024) ? diff : 1024;
            m_now = (m_now > m_tgt) ? m_now - stp : m_now + stp;
        end
        if (apply && ok) begin
            m_pct = (m_sh[1] == 0) ? 1 : m_sh[1];
            m_len = m_sh[2];
            m_min = m_sh[3];
            m_tgt = (m_sh[0] == 0) ? 1 : m_sh[0];
            if (!RAMP_EN) m_now = m_tgt;
        end
        if (clr) m_err = 0;
        if (apply && !ok) m_err = 1;
        if (commit) m_pend = 1;
        else if (apply) m_pend = 0;
        if (wr && (a < 3'd4)) m_sh[a] = d & field_mask(a);
    endtask

    // Drive one cycle of inputs, step the model, compare after the edge
    task automatic cyc(input logic wr, input logic rd, input logic [2:0] a,
                       input logic [31:0] d, input logic sync, input logic tick);
        bus_if.bus_wr    = wr;
        bus_if.bus_rd    = rd;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        pwm_sync         = sync;
        step_tick        = tick;
        model_step(wr, rd, a, d, sync, tick);
        @(posedge clk);
        #1;
        bus_if.bus_wr = 1'b0;
        bus_if.bus_rd = 1'b0;
        pwm_sync      = 1'b0;
        step_tick     = 1'b0;
        check("rvalid", 32'(bus_if.bus_rvalid), 32'(exp_rvalid));
        if (exp_rvalid) check("rdata", bus_if.bus_rdata, exp_rdata);
        check("reload", 32'(reload_out), m_now);
        check("pct", 32'(pct_out), m_pct);
        check("len", 32'(len_out), m_len);
        check("min", 32'(min_out), m_min);
        check("busy", 32'(busy_out), 32'((m_now != m_tgt) || m_pend));
        check("err", 32'(err_out), 32'(m_err));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cyc(1'b0, 1'b1, a, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic sync, input logic tick);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, sync, tick);
    endtask

    // Assert reset away from any clock edge and verify outputs settle at once
    task automatic do_reset();
        #20;
        rst = 1'b1;
        #1;
        check("rst_reload", 32'(reload_out), 32'd1666667);
        check("rst_pct", 32'(pct_out), 32'd16);
        check("rst_len", 32'(len_out), 32'd512);
        check("rst_min", 32'(min_out), 32'd32);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_rvalid", 32'(bus_if.bus_rvalid), 32'd0);
        check("rst_rdata", bus_if.bus_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    localparam int unsigned RST_READS [7] = '{1666667, 16, 512, 32, 0, 0, 1666667};

    initial begin
        logic [31:0] d;
        logic [2:0]  a;
        int unsigned r;
        logic        wr, rd;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        pwm_sync = 1'b0;
        step_tick = 1'b0;
        bus_if.bus_wr = 1'b0;
        bus_if.bus_rd = 1'b0;
        bus_if.bus_addr = '0;
        bus_if.bus_wdata = '0;
        model_reset();
        #10;
        do_reset();

        // Reset readback of addresses 0-6
        for (int i = 0; i < 7; i++) begin
            rd_reg(3'(i));
            check("rst_read", bus_if.bus_rdata, RST_READS[i]);
        end
        idle(1'b0, 1'b0);
        check("rvalid_drop", 32'(bus_if.bus_rvalid), 32'd0);

        // Commit with coincident pwm_sync waits for the next boundary
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd2, 32'd400);
        wr_reg(3'd3, 32'd40);
        cyc(1'b1, 1'b0, 3'd4, 32'd1, 1'b1, 1'b0);
        check("pend_busy", 32'(busy_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1'b0);
            check("hold_len", 32'(len_out), 32'd512);
        end
        idle(1'b1, 1'b0);
        check("apply_pct", 32'(pct_out), 32'd1);
        check("apply_len", 32'(len_out), 32'd400);
        check("apply_min", 32'(min_out), 32'd40);
        rd_reg(3'd5);
        check("apply_status", bus_if.bus_rdata, 32'd0);

        // Min below floor is rejected; err_clr clears; err_clr vs reject
        do_reset();
        wr_reg(3'd3, 32'd16);
        wr_reg(3'd4, 32'd1);
        idle(1'b1, 1'b0);
        check("floor_err", 32'(err_out), 32'd1);
        check("floor_len", 32'(len_out), 32'd512);
        check("floor_min", 32'(min_out), 32'd32);
        wr_reg(3'd4, 32'd2);
        check("errclr", 32'(err_out), 32'd0);
        wr_reg(3'd4, 32'd1);
        cyc(1'b1, 1'b0, 3'd4, 32'd2, 1'b1, 1'b0);
        check("set_wins", 32'(err_out), 32'd1);

        // Min equal to len is rejected
        do_reset();
        wr_reg(3'd3, 32'd512);
        wr_reg(3'd4, 32'd1);
        idle(1'b1, 1'b0);
        check("min_eq_len", 32'(err_out), 32'd1);

        // Reload slew (or immediate load without slewing)
        do_reset();
        wr_reg(3'd0, 32'd1664000);
        wr_reg(3'd4, 32'd1);
        idle(1'b1, 1'b0);
        check("slew0", 32'(reload_out), RAMP_EN ? 32'd1666667 : 32'd1664000);
        idle(1'b0, 1'b1);
        check("slew1", 32'(reload_out), RAMP_EN ? 32'd1665643 : 32'd1664000);
        idle(1'b0, 1'b1);
        check("slew2", 32'(reload_out), RAMP_EN ? 32'd1664619 : 32'd1664000);
        check("slew2_busy", 32'(busy_out), RAMP_EN ? 32'd1 : 32'd0);
        idle(1'b0, 1'b1);
        check("slew3", 32'(reload_out), 32'd1664000);
        check("slew3_busy", 32'(busy_out), 32'd0);

        // Async reset with err set and a ramp in flight
        do_reset();
        wr_reg(3'd3, 32'd16);
        wr_reg(3'd4, 32'd1);
        idle(1'b1, 1'b0);
        wr_reg(3'd3, 32'd40);
        wr_reg(3'd1, 32'd50);
        wr_reg(3'd0, 32'd1660000);
        wr_reg(3'd4, 32'd1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        check("pre_rst_pct", 32'(pct_out), 32'd50);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            wr = 1'b0;
            if (r < 30) begin
                wr = 1'b1;
                a  = 3'($urandom_range(0, 3));
                case (a)
                    3'd0: d = ($urandom_range(0, 9) == 0) ? 32'd0 :
                              ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(1655000, 1675000));
                    3'd1: d = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
                    3'd2: d = ($urandom_range(0, 9) == 0) ? 32'd0 :
                              ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 700));
                    default: d = 32'($urandom_range(0, 700));
                endcase
            end else if (r < 42) begin
                wr = 1'b1;
                a  = 3'd4;
                d  = {$urandom_range(0, 1) == 0 ? 30'd0 : 30'($urandom), 2'($urandom_range(0, 3))};
            end else if (r < 50) begin
                wr = 1'b1;
                a  = 3'($urandom_range(5, 7));
            end
            rd = ($urandom_range(0, 2) == 0);
            cyc(wr, rd, a, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
